cgra_config_sequencer: RTL

Synthesizable successor to the CGRA full-system bench driver. It buffers host-supplied (address, data) configuration words in a FIFO and streams them onto the CGRA `config_addr`/`config_data` bus, one word per cycle. It then gates a parametrised number of W-bit pad stimulus sides onto the fabric for a programmed number of run cycles, capturing the fabric outputs each cycle. It sits between the host/bench interface and `top`, replacing file-driven configuration and a fixed `max_cycles` stop with a handshaked, restartable sequence.

---
 rtl/cgra_config_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cgra_config_sequencer.sv
// cgra_config_sequencer
//
// Buffers host (address, data, last) configuration words in a small FIFO,
// streams them onto the CGRA configuration bus one word per cycle, then
// gates pad stimulus onto the fabric for a programmed number of run cycles
// while capturing the fabric's pad outputs every cycle.
//
// Ports:
//   clk_in            - clock, all logic on the rising edge
//   reset_n_in        - asynchronous active-low reset
//   cfg_valid_in      - host configuration word valid
//   cfg_ready_out     - FIFO can accept a word (not full)
//   cfg_addr_in       - configuration address
//   cfg_data_in       - configuration data
//   cfg_last_in       - marks the final word of a configuration
//   start_in          - begin a sequence (honoured in IDLE/DONE only)
//   abort_in          - return to IDLE and flush the FIFO
//   run_cycles_in     - run length, latched on an accepted start
//   config_addr_out   - configuration address to the CGRA (0 = no-op)
//   config_data_out   - configuration data to the CGRA
//   pad_driver_in     - pad stimulus from the bench
//   pad_in_out        - pad inputs to the CGRA (stimulus only while running)
//   pad_out_in        - pad outputs from the CGRA
//   sample_valid_out  - capture strobe for sample_data_out
//   sample_data_out   - registered copy of pad_out_in
//   state_out         - encoded sequencer state
//   cycle_count_out   - number of run cycles completed
//   done_out          - sequence complete
module cgra_config_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_SIDES  = 4,
    parameter int PAD_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                       clk_in,
    input  logic                       reset_n_in,
    input  logic                       cfg_valid_in,
    output logic                       cfg_ready_out,
    input  logic [ADDR_W-1:0]          cfg_addr_in,
    input  logic [DATA_W-1:0]          cfg_data_in,
    input  logic                       cfg_last_in,
    input  logic                       start_in,
    input  logic                       abort_in,
    input  logic [CNT_W-1:0]           run_cycles_in,
    output logic [ADDR_W-1:0]          config_addr_out,
    output logic [DATA_W-1:0]          config_data_out,
    input  logic [NUM_SIDES*PAD_W-1:0] pad_driver_in,
    output logic [NUM_SIDES*PAD_W-1:0] pad_in_out,
    input  logic [NUM_SIDES*PAD_W-1:0] pad_out_in,
    output logic                       sample_valid_out,
    output logic [NUM_SIDES*PAD_W-1:0] sample_data_out,
    output logic [2:0]                 state_out,
    output logic [CNT_W-1:0]           cycle_count_out,
    output logic                       done_out
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam int PADS  = NUM_SIDES * PAD_W;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic              head_last;
    logic              start_ok;

    logic [CNT_W-1:0]  run_len;
    logic [CNT_W-1:0]  cycle_count;
    logic [ADDR_W-1:0] config_addr_q;
    logic [DATA_W-1:0] config_data_q;
    logic              sample_valid_q;
    logic [PADS-1:0]   sample_data_q;

    // Pointers carry an extra wrap bit so equal indices can be told apart
    // as full (wrap bits differ) or empty (wrap bits equal).
    assign fifo_full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                        (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign fifo_empty = (wr_ptr == rd_ptr);

    // Abort discards a simultaneous push and suppresses any pop.
    assign push      = cfg_valid_in && !fifo_full && !abort_in;
    assign pop       = (state == ST_CONFIG) && !fifo_empty && !abort_in;
    assign head      = fifo_mem[rd_ptr[IDX_W-1:0]];
    assign head_last = head[ENT_W-1];
    assign start_ok  = start_in && ((state == ST_IDLE) || (state == ST_DONE));

    // Next-state logic; abort takes priority over everything else.
    always_comb begin
        state_next = state;
        if (abort_in) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_in) state_next = ST_CONFIG;
                end
                ST_CONFIG: begin
                    if (pop && head_last) state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    state_next = (run_len != '0) ? ST_RUN : ST_DONE;
                end
                ST_RUN: begin
                    // The count increments on this same edge, so leaving when it
                    // reads run_len-1 gives exactly run_len run cycles.
                    if (cycle_count == (run_len - CNT_ONE)) state_next = ST_DONE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO pointers; abort flushes the queue by collapsing both pointers.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (abort_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // FIFO storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= {cfg_last_in, cfg_addr_in, cfg_data_in};
        end
    end

    // A popped word appears on the config bus for exactly one cycle; any
    // cycle without a pop drives the no-op address 0.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            config_addr_q <= '0;
            config_data_q <= '0;
        end else if (pop) begin
            config_addr_q <= head[ADDR_W+DATA_W-1:DATA_W];
            config_data_q <= head[DATA_W-1:0];
        end else begin
            config_addr_q <= '0;
            config_data_q <= '0;
        end
    end

    // Run length and completed-cycle counter; the count is held in DONE.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            run_len     <= '0;
            cycle_count <= '0;
        end else if (abort_in) begin
            cycle_count <= '0;
        end else if (start_ok) begin
            run_len     <= run_cycles_in;
            cycle_count <= '0;
        end else if (state == ST_RUN) begin
            cycle_count <= cycle_count + CNT_ONE;
        end
    end

    // Capture the fabric outputs of every run cycle; an aborted cycle is not
    // reported as a sample.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
        end else begin
            sample_valid_q <= (state == ST_RUN) && !abort_in;
            if ((state == ST_RUN) && !abort_in) sample_data_q <= pad_out_in;
        end
    end

    assign cfg_ready_out    = !fifo_full;
    assign config_addr_out  = config_addr_q;
    assign config_data_out  = config_data_q;
    assign pad_in_out       = (state == ST_RUN) ? pad_driver_in : '0;
    assign sample_valid_out = sample_valid_q;
    assign sample_data_out  = sample_data_q;
    assign state_out        = state;
    assign cycle_count_out  = cycle_count;
    assign done_out         = (state == ST_DONE);

endmodule
